// File: rtl/serial_add_sub_if.sv
// Operation handshake and operand/result bundle for the bit-serial adder/subtractor.
// The master issues operations and the slave returns results.
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement adder/subtractor, LSB first, one full-adder slice per clock.
// Subtract runs as a + ~b + ~cin. Results hold until the next completion.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_sub_if.slave  bus
);
  // state | meaning
  // IDLE  | waiting for start, busy low
  // RUN   | one bit per edge, cnt = bit being processed
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [0:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             done_q;

  logic             s_bit;
  logic             c_next;
  logic             last;
  logic [WIDTH-1:0] res_next;

  assign s_bit    = a_sr[0] ^ b_sr[0] ^ carry;
  assign c_next   = (a_sr[0] & b_sr[0]) | (b_sr[0] & carry) | (a_sr[0] & carry);
  assign res_next = {s_bit, res_sr[WIDTH-1:1]};
  assign last     = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr  <= bus.a;
            b_sr  <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.cin ^ bus.sub;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          res_sr <= res_next;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= c_next;
          cnt    <= cnt + CW'(1);
          if (last) begin
            // carry here is the carry into the MSB slice, c_next the carry out of it
            sum_q  <= res_next;
            cout_q <= c_next;
            ovf_q  <= carry ^ c_next;
            done_q <= 1'b1;
            cnt    <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: 8-bit directed/random/protocol/reset tests and
// an exhaustive 4-bit sweep, checked against plain-integer arithmetic.
module tb_serial_add_sub;
  logic clk;
  logic rst_n;

  serial_add_sub_if #(.WIDTH(8)) bus8 ();
  serial_add_sub_if #(.WIDTH(4)) bus4 ();

  serial_add_sub #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  serial_add_sub #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];
  int   checks = 0;
  int   fails  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // reference arithmetic on plain integers
  function automatic void model(input int w, input bit s, input longint a, input longint b,
                                input bit c, output longint sm, output bit co, output bit ov);
    longint lim, half, sa, sb, u, sg;
    lim  = longint'(1) << w;
    half = lim >> 1;
    sa   = (a >= half) ? a - lim : a;
    sb   = (b >= half) ? b - lim : b;
    if (!s) begin
      u  = a + b + c;
      sg = sa + sb + c;
      co = (u >= lim);
    end else begin
      u  = a - b - c;
      sg = sa - sb - c;
      co = (a >= b + c);
    end
    sm = ((u % lim) + lim) % lim;
    ov = (sg < -half) || (sg > half - 1);
  endfunction

  task automatic wait_idle8();
    int n = 0;
    @(negedge clk);
    while (bus8.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_wait8_timeout", n, 0);
  endtask

  task automatic issue8x(input bit s, input logic [7:0] a, input logic [7:0] b, input bit c,
                         input logic [7:0] esum, input bit ecout, input bit eovf);
    exp_t e;
    wait_idle8();
    bus8.start = 1'b1;
    bus8.sub   = s;
    bus8.a     = a;
    bus8.b     = b;
    bus8.cin   = c;
    e.sum = esum; e.cout = ecout; e.ovf = eovf;
    q8.push_back(e);
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  task automatic issue8(input bit s, input logic [7:0] a, input logic [7:0] b, input bit c);
    longint sm; bit co, ov;
    model(8, s, longint'(a), longint'(b), c, sm, co, ov);
    issue8x(s, a, b, c, sm[7:0], co, ov);
  endtask

  task automatic issue4(input bit s, input logic [3:0] a, input logic [3:0] b, input bit c);
    longint sm; bit co, ov; exp_t e; int n = 0;
    model(4, s, longint'(a), longint'(b), c, sm, co, ov);
    @(negedge clk);
    while (bus4.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_wait4_timeout", n, 0);
    bus4.start = 1'b1;
    bus4.sub = s; bus4.a = a; bus4.b = b; bus4.cin = c;
    e.sum = {4'b0, sm[3:0]}; e.cout = co; e.ovf = ov;
    q4.push_back(e);
    @(negedge clk);
    bus4.start = 1'b0;
  endtask

  task automatic wait_done8();
    int n = 0;
    while (!bus8.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("done_wait8_timeout", n, 0);
  endtask

  // monitors: pop and compare whenever a DUT presents done
  always @(negedge clk) begin
    if (rst_n && bus8.done) begin
      if (q8.size() == 0) chk("unexpected_done8", 1, 0);
      else begin
        exp_t e;
        e = q8.pop_front();
        chk("sum8", bus8.sum, e.sum);
        chk("cout8", bus8.cout, e.cout);
        chk("ovf8", bus8.ovf, e.ovf);
        chk("busy8_in_done", bus8.busy, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus4.done) begin
      if (q4.size() == 0) chk("unexpected_done4", 1, 0);
      else begin
        exp_t e;
        e = q4.pop_front();
        chk("sum4", {4'b0, bus4.sum}, e.sum);
        chk("cout4", bus4.cout, e.cout);
        chk("ovf4", bus4.ovf, e.ovf);
      end
    end
  end

  initial begin
    int lat, bcnt, n;
    bit unstable;
    logic [7:0] held;

    rst_n = 1'b0;
    bus8.start = 0; bus8.sub = 0; bus8.a = '0; bus8.b = '0; bus8.cin = 0;
    bus4.start = 0; bus4.sub = 0; bus4.a = '0; bus4.b = '0; bus4.cin = 0;
    #12;
    chk("rst_busy", bus8.busy, 0);
    chk("rst_done", bus8.done, 0);
    chk("rst_sum", bus8.sum, 0);
    chk("rst_cout_ovf", {bus8.cout, bus8.ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // timed add: latency, busy width, sum stability during RUN
    wait_idle8();
    bus8.start = 1'b1; bus8.sub = 0; bus8.a = 8'h35; bus8.b = 8'h4A; bus8.cin = 0;
    q8.push_back('{sum: 8'h7F, cout: 1'b0, ovf: 1'b0});
    held = bus8.sum; lat = 0; bcnt = 0; unstable = 0;
    do begin
      @(negedge clk);
      lat++;
      bus8.start = 1'b0;
      if (bus8.busy) begin
        bcnt++;
        if (bus8.sum !== held) unstable = 1;
      end
    end while (!bus8.done && lat < 40);
    chk("latency", lat, 9);
    chk("busy_cycles", bcnt, 8);
    chk("sum_stable_run", unstable, 0);

    issue8x(0, 8'hFF, 8'h01, 1, 8'h01, 1, 0);
    issue8x(0, 8'h7F, 8'h01, 0, 8'h80, 0, 1);
    issue8x(1, 8'h10, 8'h20, 0, 8'hF0, 0, 0);
    issue8x(1, 8'h80, 8'h01, 0, 8'h7F, 1, 1);
    issue8x(1, 8'h05, 8'h05, 1, 8'hFF, 0, 0);

    // start mid-RUN with other operands must be ignored
    issue8x(0, 8'h12, 8'h34, 0, 8'h46, 0, 0);
    @(negedge clk);
    @(negedge clk);
    bus8.start = 1'b1; bus8.sub = 1; bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1;
    @(negedge clk);
    bus8.start = 1'b0;
    wait_done8();

    // start in the done cycle is accepted with no idle gap
    issue8(0, 8'h21, 8'h43, 1);
    wait_done8();
    bus8.start = 1'b1; bus8.sub = 1; bus8.a = 8'h40; bus8.b = 8'h41; bus8.cin = 0;
    q8.push_back('{sum: 8'hFF, cout: 1'b0, ovf: 1'b0});
    @(negedge clk);
    bus8.start = 1'b0;
    chk("b2b_busy", bus8.busy, 1);

    repeat (150) issue8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

    // reset around bit 3 of an operation
    issue8(0, 8'h5A, 8'h33, 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", bus8.busy, 0);
    chk("midrst_done", bus8.done, 0);
    chk("midrst_sum", bus8.sum, 0);
    chk("midrst_cout_ovf", {bus8.cout, bus8.ovf}, 0);
    q8.delete();
    q4.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("no_done_after_rst", bus8.busy, 0);
    issue8x(0, 8'h5A, 8'h33, 0, 8'h8D, 0, 1);

    // exhaustive 4-bit sweep
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 2; c++)
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 16; b++)
            issue4(1'(s), 4'(a), 4'(b), 1'(c));

    n = 0;
    while ((q8.size() != 0 || q4.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", q8.size() + q4.size(), 0);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
